// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
//   Key event bus from the keypad scanner to its consumer (the operand input
//   controller).
//
//   Signals:
//     key_pulse  one-cycle strobe per accepted press (and per repeat)
//     key_code   4-bit code of the last accepted key, held between presses
//     key_held   high while a debounced key is down
//
//   Modports:
//     master  driven by the scanner
//     slave   observed by the consumer
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
   logic       key_pulse;
   logic [3:0] key_code;
   logic       key_held;

   modport master (output key_pulse, output key_code, output key_held);
   modport slave  (input  key_pulse, input  key_code, input  key_held);
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, synchronizes
//   and debounces the row inputs, and reports each debounced press as a
//   single-cycle key_pulse with a 4-bit key_code.
//
//   Parameters:
//     SCAN_CYCLES      cycles each column is driven before sampling (>= 2)
//     DEBOUNCE_CYCLES  consecutive stable cycles to accept press/release (>= 1)
//     REPEAT_CYCLES    auto-repeat period while held (KEYPAD_REPEAT_EN only)
//
//   Ports:
//     clk      system clock
//     rst_n    asynchronous active-low reset
//     row_n    keypad rows, active-low, asynchronous to clk
//     col_n    column drive, one-hot active-low (registered)
//     key      keypad_scanner_if.master: key_pulse, key_code, key_held
//
//   Build option:
//     KEYPAD_REPEAT_EN  when defined, a held key re-pulses every
//                       REPEAT_CYCLES cycles spent in the pressed state.
// ---------------------------------------------------------------------------
module keypad_scanner #(
   parameter int unsigned SCAN_CYCLES     = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned REPEAT_CYCLES   = 13500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   keypad_scanner_if.master key
);

   if (SCAN_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("keypad_scanner: illegal parameter values");
   end

   localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned        REP_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0]              rep_cnt;
`endif

   typedef enum logic [1:0] {
      SCAN,
      DB_PRESS,
      PRESSED,
      DB_RELEASE
   } state_t;

   state_t            state;
   logic [3:0]        row_meta;
   logic [3:0]        row_s;
   logic [1:0]        col_idx;
   logic [1:0]        col_next;
   logic [SCAN_W-1:0] scan_cnt;
   logic [DB_W-1:0]   db_cnt;
   logic [1:0]        key_row;
   logic [1:0]        key_col;
   logic              key_pulse_r;
   logic [3:0]        key_code_r;
   logic              key_held_r;

   assign key.key_pulse = key_pulse_r;
   assign key.key_code  = key_code_r;
   assign key.key_held  = key_held_r;

   assign col_next = col_idx + 2'd1;

   // Lowest-index active (low) row wins when several rows are down.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      lowest_low = 2'd0;
      if (!rows[0])      lowest_low = 2'd0;
      else if (!rows[1]) lowest_low = 2'd1;
      else if (!rows[2]) lowest_low = 2'd2;
      else if (!rows[3]) lowest_low = 2'd3;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      key_map = '0;
      case ({row, col})
         4'b00_00: key_map = 4'h1;
         4'b00_01: key_map = 4'h2;
         4'b00_10: key_map = 4'h3;
         4'b00_11: key_map = 4'hA;
         4'b01_00: key_map = 4'h4;
         4'b01_01: key_map = 4'h5;
         4'b01_10: key_map = 4'h6;
         4'b01_11: key_map = 4'hB;
         4'b10_00: key_map = 4'h7;
         4'b10_01: key_map = 4'h8;
         4'b10_10: key_map = 4'h9;
         4'b10_11: key_map = 4'hC;
         4'b11_00: key_map = 4'hE;
         4'b11_01: key_map = 4'h0;
         4'b11_10: key_map = 4'hF;
         4'b11_11: key_map = 4'hD;
         default:  key_map = '0;
      endcase
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      col_drive = ~(4'b0001 << idx);
   endfunction

   // Two-stage synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= '1;
         row_s    <= '1;
      end else begin
         row_meta <= row_n;
         row_s    <= row_meta;
      end
   end

   // col_n is updated together with col_idx so the drive stays registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SCAN;
         col_idx     <= '0;
         col_n       <= 4'b1110;
         scan_cnt    <= '0;
         db_cnt      <= '0;
         key_row     <= '0;
         key_col     <= '0;
         key_pulse_r <= 1'b0;
         key_code_r  <= '0;
         key_held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt     <= '0;
`endif
      end else begin
         key_pulse_r <= 1'b0;
         case (state)
            SCAN: begin
               if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  if (row_s != 4'b1111) begin
                     key_row <= lowest_low(row_s);
                     key_col <= col_idx;
                     db_cnt  <= '0;
                     state   <= DB_PRESS;
                  end else begin
                     col_idx <= col_next;
                     col_n   <= col_drive(col_next);
                  end
               end else begin
                  scan_cnt <= scan_cnt + 1'b1;
               end
            end

            DB_PRESS: begin
               if (row_s[key_row]) begin
                  state    <= SCAN;
                  col_idx  <= col_next;
                  col_n    <= col_drive(col_next);
                  scan_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state       <= PRESSED;
                  key_pulse_r <= 1'b1;
                  key_code_r  <= key_map(key_row, key_col);
                  key_held_r  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt     <= '0;
`endif
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end

            PRESSED: begin
               if (row_s[key_row]) begin
                  state  <= DB_RELEASE;
                  db_cnt <= '0;
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  if (rep_cnt == REP_LAST) begin
                     key_pulse_r <= 1'b1;
                     rep_cnt     <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
`endif
               end
            end

            DB_RELEASE: begin
               if (!row_s[key_row]) begin
                  state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt <= '0;
`endif
               end else if (db_cnt == DB_LAST) begin
                  state      <= SCAN;
                  key_held_r <= 1'b0;
                  col_idx    <= col_next;
                  col_n      <= col_drive(col_next);
                  scan_cnt   <= '0;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end

            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Drives a simulated 4x4 keypad (pressed-key matrix plus a row "bounce"
//   override) against keypad_scanner and compares every output, every cycle,
//   with a behavioural model of the scan/debounce rules, plus directed
//   scenario checks (reset, column walk, clean press, bounces, two keys,
//   reset mid-debounce, auto-repeat) and a randomized press sequence.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int S = 4;
   localparam int D = 8;
   localparam int R = 20;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [15:0] keys;      // bit r*4+c: key at row r / column c held down
   logic [3:0]  force_hi;  // rows forced open to emulate contact bounce

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_CYCLES    (S),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .row_n (row_n),
      .col_n (col_n),
      .key   (kif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Physical keypad: a pressed key shorts its row to its column.
   always_comb begin
      logic [3:0] rn;
      rn = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_n[c]) rn[r] = 1'b0;
      row_n = rn | force_hi;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   int         cyc;
   int         m_phase;   // 0 scanning, 1 confirming press, 2 down, 3 confirming release
   int         m_col, m_wait, m_run, m_rep, m_row, m_key, m_entry;
   logic [3:0] m_meta, m_rs;
   logic       e_pulse, e_held;
   logic [3:0] e_code;

   task automatic model_reset();
      m_phase = 0; m_col = 0; m_wait = S; m_run = 0; m_rep = 0;
      m_row = 0; m_key = 0;
      m_meta = 4'hF; m_rs = 4'hF;
      e_pulse = 1'b0; e_held = 1'b0; e_code = 4'h0;
   endtask

   task automatic model_step();
      logic [3:0] rs;
      rs     = m_rs;
      m_rs   = m_meta;
      m_meta = row_n;
      e_pulse = 1'b0;
      case (m_phase)
         0: begin
            m_wait--;
            if (m_wait == 0) begin
               m_wait = S;
               if (rs != 4'hF) begin
                  for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
                  m_key   = keymap[m_row*4 + m_col];
                  m_run   = 0;
                  m_phase = 1;
                  m_entry = cyc;
               end else begin
                  m_col = (m_col + 1) % 4;
               end
            end
         end
         1: begin
            if (rs[m_row]) begin
               m_phase = 0; m_col = (m_col + 1) % 4; m_wait = S;
            end else begin
               m_run++;
               if (m_run == D) begin
                  m_phase = 2; e_pulse = 1'b1; e_code = 4'(m_key); e_held = 1'b1; m_rep = 0;
               end
            end
         end
         2: begin
            if (rs[m_row]) begin
               m_phase = 3; m_run = 0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
               m_rep++;
               if (m_rep == R) begin
                  e_pulse = 1'b1; m_rep = 0;
               end
`endif
            end
         end
         default: begin
            if (!rs[m_row]) begin
               m_phase = 2; m_rep = 0;
            end else begin
               m_run++;
               if (m_run == D) begin
                  m_phase = 0; e_held = 1'b0; m_col = (m_col + 1) % 4; m_wait = S;
               end
            end
         end
      endcase
   endtask

   initial begin
      cyc = 0;
      m_entry = 0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            cyc++;
            model_step();
         end
      end
   end

   // ---------------- per-cycle comparison and pulse bookkeeping ----------------
   int   pulse_cnt = 0;
   int   pulse_times[$];
   logic prev_pulse = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #3;
         check("col_n",     col_n,         4'hF ^ (4'h1 << m_col));
         check("key_pulse", kif.key_pulse, e_pulse);
         check("key_code",  kif.key_code,  e_code);
         check("key_held",  kif.key_held,  e_held);
         check("no_double_pulse", kif.key_pulse & prev_pulse, 1'b0);
         prev_pulse = kif.key_pulse;
         if (kif.key_pulse === 1'b1) begin
            pulse_cnt++;
            pulse_times.push_back(cyc);
         end
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_pulse(input string tag, input int budget);
      int start;
      int n;
      start = pulse_cnt;
      n = 0;
      while (pulse_cnt == start && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_pulse_wait"}, pulse_cnt != start, 1'b1);
   endtask

   task automatic wait_phase(input string tag, input int ph, input int budget);
      int n;
      n = 0;
      while (m_phase != ph && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_phase_wait"}, m_phase == ph, 1'b1);
   endtask

   task automatic wait_held(input string tag, input logic val, input int budget);
      int n;
      n = 0;
      while (kif.key_held !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_held_wait"}, kif.key_held, val);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic held_min;
      int   a;
      rst_n    = 1'b0;
      keys     = '0;
      force_hi = '0;

      // Reset values and free-running column walk.
      repeat (5) @(negedge clk);
      check("rst_col",   col_n,         4'b1110);
      check("rst_pulse", kif.key_pulse, 1'b0);
      check("rst_code",  kif.key_code,  4'h0);
      check("rst_held",  kif.key_held,  1'b0);
      rst_n = 1'b1;
      for (int j = 1; j <= 32; j++) begin
         @(posedge clk);
         #4;
         check("walk_col",   col_n,         4'hF ^ (4'h1 << ((j / 4) % 4)));
         check("walk_pulse", kif.key_pulse, 1'b0);
         check("walk_code",  kif.key_code,  4'h0);
      end
      @(negedge clk);

      // Clean press of "5" (row 1 / col 1), held 40 cycles.
      pulse_cnt = 0;
      keys[5] = 1'b1;
      wait_pulse("p5", 200);
      check("p5_code",    kif.key_code, 4'h5);
      check("p5_latency", pulse_times[pulse_times.size()-1] - m_entry, D);
      repeat (40) @(negedge clk);
      check("p5_held", kif.key_held, 1'b1);
`ifdef KEYPAD_REPEAT_EN
      check("p5_count", pulse_cnt, 3);
`else
      check("p5_count", pulse_cnt, 1);
`endif
      keys = '0;
      wait_held("p5_rel", 1'b0, 100);
      check("p5_resume_col", col_n, 4'b1011);

      // Bounce during press confirmation on "0" (row 3 / col 1).
      pulse_cnt = 0;
      keys[13] = 1'b1;
      wait_phase("pb", 1, 200);
      repeat (3) @(negedge clk);
      force_hi = 4'b1000;
      @(negedge clk);
      force_hi = '0;
      wait_phase("pb_abandon", 0, 20);
      check("pb_nopulse", pulse_cnt, 0);
      wait_pulse("pb_retry", 200);
      check("pb_code",  kif.key_code, 4'h0);
      check("pb_count", pulse_cnt, 1);
      keys = '0;
      wait_held("pb_rel", 1'b0, 100);

      // Bounce during hold on "A" (row 0 / col 3).
      pulse_cnt = 0;
      keys[3] = 1'b1;
      wait_pulse("rb", 200);
      repeat (2) @(negedge clk);
      held_min = 1'b1;
      force_hi = 4'b0001;
      repeat (5) begin
         @(negedge clk);
         held_min &= kif.key_held;
      end
      force_hi = '0;
      repeat (12) begin
         @(negedge clk);
         held_min &= kif.key_held;
      end
      check("rb_held",  held_min,     1'b1);
      check("rb_count", pulse_cnt,    1);
      check("rb_code",  kif.key_code, 4'hA);
      keys = '0;
      wait_held("rb_rel", 1'b0, 100);

      // Two keys in column 0: rows 0 and 2, lowest row wins.
      pulse_cnt = 0;
      keys[0] = 1'b1;
      keys[8] = 1'b1;
      wait_pulse("two", 200);
      check("two_code", kif.key_code, 4'h1);
      repeat (5) @(negedge clk);
      check("two_count", pulse_cnt, 1);
      keys = '0;
      wait_held("two_rel", 1'b0, 100);

      // Reset asserted mid press-confirmation on "6".
      pulse_cnt = 0;
      keys[6] = 1'b1;
      wait_phase("rm", 1, 200);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      keys = '0;
      check("rm_col",   col_n,         4'b1110);
      check("rm_pulse", kif.key_pulse, 1'b0);
      check("rm_code",  kif.key_code,  4'h0);
      check("rm_held",  kif.key_held,  1'b0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("rm_count", pulse_cnt, 0);

      // Hold "9" (row 2 / col 2) for 70 cycles after acceptance.
      pulse_cnt = 0;
      pulse_times.delete();
      keys[10] = 1'b1;
      wait_pulse("rep", 200);
      repeat (69) @(negedge clk);
      check("rep_code", kif.key_code, 4'h9);
`ifdef KEYPAD_REPEAT_EN
      check("rep_count", pulse_cnt, 4);
      for (int i = 1; i <= 3; i++) begin
         a = (pulse_times.size() > i) ? pulse_times[i] - pulse_times[0] : -1;
         check("rep_offset", a, 20 * i);
      end
`else
      check("rep_count", pulse_cnt, 1);
`endif
      keys = '0;
      wait_held("rep_rel", 1'b0, 100);

      // Randomized presses with random bounce; the model checks every cycle.
      for (int it = 0; it < 30; it++) begin
         keys = '0;
         keys[$urandom_range(15)] = 1'b1;
         repeat ($urandom_range(60)) begin
            @(negedge clk);
            force_hi = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
         end
         @(negedge clk);
         force_hi = '0;
         keys = '0;
         wait_held("rnd_rel", 1'b0, 100);
         repeat ($urandom_range(40)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
